// File: rtl/io_pwr_seq.sv
`timescale 1ns/1ps
// io_pwr_seq: IO-ring power sequencer.
// Qualifies the IO-supply power-good, releases core-to-IO isolation, then
// staggers pad-bank enables to limit simultaneous-switching current on the
// shared rails. A power-good loss drops everything at once and latches a fault.
module io_pwr_seq #(
  parameter int NUM_BANKS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGGER_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwr_ok_i,
  input  logic                 seq_start_i,
  input  logic                 fault_clr_i,
  output logic                 iso_n_o,
  output logic [NUM_BANKS-1:0] bank_en_o,
  output logic                 ready_o,
  output logic                 fault_o,
  output logic [2:0]           state_o
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_BANK = IDX_W'(NUM_BANKS - 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    DEBOUNCE = 3'd1,
    ISO_REL  = 3'd2,
    RAMP_UP  = 3'd3,
    ON       = 3'd4,
    RAMP_DN  = 3'd5,
    FAULT    = 3'd6
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_iso;
  logic [NUM_BANKS-1:0] r_bankEn;
  logic                 r_ready;
  logic                 r_fault;

  logic                 w_pwrOk;
  logic                 w_released;
  logic [IDX_W-1:0]     w_idxNext;
  logic [IDX_W-1:0]     w_idxPrev;

  assign w_pwrOk    = r_sync2;
  assign w_idxNext  = r_idx + IDX_W'(1);
  assign w_idxPrev  = r_idx - IDX_W'(1);
  assign w_released = (r_state == ISO_REL) || (r_state == RAMP_UP) ||
                      (r_state == ON) || (r_state == RAMP_DN);

  assign iso_n_o   = r_iso;
  assign bank_en_o = r_bankEn;
  assign ready_o   = r_ready;
  assign fault_o   = r_fault;
  assign state_o   = r_state;

  // Two-flop synchronizer bringing the asynchronous power-good into clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwr_ok_i;
      r_sync2 <= r_sync1;
    end
  end

  // Sequencer FSM; power loss while anything is released overrides every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= OFF;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_iso    <= 1'b0;
      r_bankEn <= '0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_released && !w_pwrOk) begin
      r_state  <= FAULT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_iso    <= 1'b0;
      r_bankEn <= '0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b1;
    end else begin
      case (r_state)
        OFF: begin
          r_iso    <= 1'b0;
          r_bankEn <= '0;
          r_ready  <= 1'b0;
          if (seq_start_i && !r_fault) begin
            r_state <= DEBOUNCE;
            r_cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!seq_start_i) begin
            r_state <= OFF;
            r_cnt   <= '0;
          end else if (!w_pwrOk) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LIMIT) begin
            r_state <= ISO_REL;
            r_iso   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ISO_REL: begin
          r_state  <= RAMP_UP;
          r_bankEn <= NUM_BANKS'(1);
          r_idx    <= '0;
          r_cnt    <= '0;
        end
        RAMP_UP: begin
          if (!seq_start_i) begin
            r_state         <= RAMP_DN;
            r_ready         <= 1'b0;
            r_bankEn[r_idx] <= 1'b0;
            r_cnt           <= '0;
          end else if (r_cnt == STG_LAST) begin
            r_cnt <= '0;
            if (r_idx == LAST_BANK) begin
              r_state <= ON;
              r_ready <= 1'b1;
            end else begin
              r_idx               <= w_idxNext;
              r_bankEn[w_idxNext] <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ON: begin
          if (!seq_start_i) begin
            r_state         <= RAMP_DN;
            r_ready         <= 1'b0;
            r_bankEn[r_idx] <= 1'b0;
            r_cnt           <= '0;
          end
        end
        RAMP_DN: begin
          if (r_bankEn == '0) begin
            r_state <= OFF;
            r_iso   <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == STG_LAST) begin
            r_bankEn[w_idxPrev] <= 1'b0;
            r_idx               <= w_idxPrev;
            r_cnt               <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FAULT: begin
          r_iso    <= 1'b0;
          r_bankEn <= '0;
          r_ready  <= 1'b0;
          if (fault_clr_i) begin
            r_fault <= 1'b0;
            r_state <= OFF;
          end
        end
        default: begin
          r_state  <= OFF;
          r_iso    <= 1'b0;
          r_bankEn <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_pwr_seq.sv
`timescale 1ns/1ps
// tb_io_pwr_seq: directed bench for the IO power sequencer.
// Cycle numbers in comments count clock edges after the stimulus was driven.
module tb_io_pwr_seq;

  logic       clk = 1'b0;
  logic       rst, pwrOk, seqStart, faultClr;
  logic       isoN, ready, fault;
  logic [3:0] bankEn;
  logic [2:0] state;

  logic       sRst, sPwrOk, sSeqStart, sFaultClr;
  logic       sIsoN, sReady, sFault;
  logic [0:0] sBankEn;
  logic [2:0] sState;

  int nChecks = 0;
  int nErrors = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  io_pwr_seq #(.NUM_BANKS(4), .DEBOUNCE_CYCLES(16), .STAGGER_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pwr_ok_i(pwrOk), .seq_start_i(seqStart), .fault_clr_i(faultClr),
    .iso_n_o(isoN), .bank_en_o(bankEn), .ready_o(ready), .fault_o(fault), .state_o(state)
  );

  io_pwr_seq #(.NUM_BANKS(1), .DEBOUNCE_CYCLES(1), .STAGGER_CYCLES(1), .CNT_W(8)) dutSmall (
    .clk(clk), .rst(sRst), .pwr_ok_i(sPwrOk), .seq_start_i(sSeqStart), .fault_clr_i(sFaultClr),
    .iso_n_o(sIsoN), .bank_en_o(sBankEn), .ready_o(sReady), .fault_o(sFault), .state_o(sState)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMain(input string tag, input logic [31:0] expIso, input logic [31:0] expBank,
                           input logic [31:0] expReady, input logic [31:0] expFault, input logic [31:0] expState);
    checkOutput({tag, " iso"},   32'(isoN),   expIso);
    checkOutput({tag, " bank"},  32'(bankEn), expBank);
    checkOutput({tag, " ready"}, 32'(ready),  expReady);
    checkOutput({tag, " fault"}, 32'(fault),  expFault);
    checkOutput({tag, " state"}, 32'(state),  expState);
  endtask

  task automatic applyStimulus(input logic seq, input logic pwr, input logic clr);
    seqStart = seq;
    pwrOk    = pwr;
    faultClr = clr;
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitState(input string tag, input logic [2:0] target, input int budget);
    int i = 0;
    while (state !== target && i < budget) begin
      stepCycle(1);
      i++;
    end
    checkOutput(tag, 32'(state), 32'(target));
  endtask

  // Directed scenarios run back to back; the main DUT is left in a known state after each.
  initial begin
    logic [3:0] expBank;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    sRst = 1'b1; sPwrOk = 1'b0; sSeqStart = 1'b0; sFaultClr = 1'b0;
    stepCycle(3);
    checkMain("reset", 0, 0, 0, 0, 0);
    checkOutput("small reset iso", 32'(sIsoN), 0);
    checkOutput("small reset bank", 32'(sBankEn), 0);
    checkOutput("small reset state", 32'(sState), 0);
    rst = 1'b0;
    sRst = 1'b0;

    // Power-up with defaults
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle(3);
    checkMain("t1 wait", 0, 0, 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int n = 1; n <= 52; n++) begin
      stepCycle(1);
      if (n < 20)      expBank = 4'b0000;
      else if (n < 28) expBank = 4'b0001;
      else if (n < 36) expBank = 4'b0011;
      else if (n < 44) expBank = 4'b0111;
      else             expBank = 4'b1111;
      checkOutput($sformatf("t1 iso c%0d", n),   32'(isoN),   (n >= 19) ? 1 : 0);
      checkOutput($sformatf("t1 bank c%0d", n),  32'(bankEn), 32'(expBank));
      checkOutput($sformatf("t1 ready c%0d", n), 32'(ready),  (n >= 52) ? 1 : 0);
    end
    checkOutput("t1 state on", 32'(state), 4);

    // Glitch during debounce restarts qualification
    rst = 1'b1;
    stepCycle(1);
    rst = 1'b0;
    checkMain("t2 reset", 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle(10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle(18);
    checkMain("t2 c18", 0, 0, 0, 0, 1);
    stepCycle(1);
    checkMain("t2 c19", 1, 0, 0, 0, 2);
    stepCycle(33);
    checkMain("t2 on", 1, 'hF, 1, 0, 4);

    // Power loss in ON
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle(2);
    checkMain("t3 c2", 1, 'hF, 1, 0, 4);
    stepCycle(1);
    checkMain("t3 c3", 0, 0, 0, 1, 6);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle(5);
    checkMain("t3 held", 0, 0, 0, 1, 6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkMain("t3 cleared", 0, 0, 0, 0, 0);
    stepCycle(1);
    checkOutput("t3 restart", 32'(state), 1);
    waitState("t3 reach on", 3'd4, 100);

    // Orderly power-down from ON
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle(1);
    checkMain("t4 c1", 1, 'h7, 0, 0, 5);
    stepCycle(7);
    checkOutput("t4 c8 bank", 32'(bankEn), 'h7);
    stepCycle(1);
    checkOutput("t4 c9 bank", 32'(bankEn), 'h3);
    stepCycle(8);
    checkOutput("t4 c17 bank", 32'(bankEn), 'h1);
    stepCycle(8);
    checkMain("t4 c25", 1, 0, 0, 0, 5);
    stepCycle(1);
    checkMain("t4 c26", 0, 0, 0, 0, 0);

    // Power-down with two banks on; restart request ignored until OFF
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle(18);
    checkMain("t5a iso", 1, 0, 0, 0, 2);
    stepCycle(9);
    checkMain("t5a two", 1, 'h3, 0, 0, 3);
    stepCycle(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle(1);
    checkMain("t5a dn", 1, 'h1, 0, 0, 5);
    stepCycle(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle(5);
    checkMain("t5a hold", 1, 'h1, 0, 0, 5);
    stepCycle(1);
    checkMain("t5a last", 1, 0, 0, 0, 5);
    stepCycle(1);
    checkMain("t5a off", 0, 0, 0, 0, 0);
    stepCycle(1);
    checkOutput("t5a restart", 32'(state), 1);

    // Reset in the middle of the ramp
    stepCycle(17);
    checkMain("t5b iso", 1, 0, 0, 0, 2);
    stepCycle(1);
    checkMain("t5b ramp", 1, 'h1, 0, 0, 3);
    stepCycle(2);
    rst = 1'b1;
    stepCycle(1);
    checkMain("t5b rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Simultaneous power loss and power-down request
    waitState("t5c reach on", 3'd4, 200);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle(2);
    checkOutput("t5c pre", 32'(state), 4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkMain("t5c fault", 0, 0, 0, 1, 6);

    // Minimal configuration: one bank, unit debounce and stagger
    sSeqStart = 1'b1;
    sPwrOk    = 1'b1;
    stepCycle(3);
    checkOutput("t6 c3 iso", 32'(sIsoN), 0);
    checkOutput("t6 c3 state", 32'(sState), 1);
    stepCycle(1);
    checkOutput("t6 c4 iso", 32'(sIsoN), 1);
    checkOutput("t6 c4 bank", 32'(sBankEn), 0);
    stepCycle(1);
    checkOutput("t6 c5 bank", 32'(sBankEn), 1);
    checkOutput("t6 c5 ready", 32'(sReady), 0);
    stepCycle(1);
    checkOutput("t6 c6 ready", 32'(sReady), 1);
    checkOutput("t6 c6 state", 32'(sState), 4);
    checkOutput("t6 c6 fault", 32'(sFault), 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
